// File: rtl/serial_word_deserializer_if.sv
// Serial-in / word-out bundle between the shifter control, the deserializer and its consumer.
// master drives bits and the consumer handshake; slave is the deserializer itself.
interface serial_word_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             overrun_clr;
  logic             frame_err;
  logic             busy;

  modport master (
    output sin, sin_valid, sof, dout_ready, overrun_clr,
    input  dout, dout_valid, overrun, frame_err, busy
  );

  modport slave (
    input  sin, sin_valid, sof, dout_ready, overrun_clr,
    output dout, dout_valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Reassembles an LSB-first serial stream into WIDTH-bit words; word valid 1 cycle after its last bit.
// One-word holding buffer: a word completing while the buffer is full and not draining is dropped (overrun).
module serial_word_deserializer #(
  parameter int WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  serial_word_deserializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic [WIDTH-1:0] start_word;
  logic [WIDTH-1:0] shifted_word;
  logic             complete;
  logic             drop;

  // New bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
  assign start_word   = WIDTH'(bus.sin) << (WIDTH - 1);
  assign shifted_word = (sreg_q >> 1) | start_word;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    frame_err_d = 1'b0;

    if (bus.sin_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.sof) begin
            sreg_d = start_word;
            if (WIDTH == 1) begin
              complete = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d   = CW'(1);
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          if (bus.sof) begin
            frame_err_d = 1'b1;
            sreg_d      = start_word;
            cnt_d       = CW'(1);
          end else begin
            sreg_d = shifted_word;
            if (cnt_q == CW'(WIDTH - 1)) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    drop         = 1'b0;

    if (complete) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = sreg_d;
        dout_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    // A drop on the same edge as a clear must leave the flag set.
    if (bus.overrun_clr) overrun_d = 1'b0;
    if (drop)            overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q == SHIFT);

endmodule
